// File: rtl/tf_word_ctrl.sv
// Word-serial front end for the Twofish datapath core: packs four input words
// into a block, applies optional CBC chaining, sequences the core handshake and
// returns the 128-bit result as four output words.
module tf_word_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [127:0] Key,
  input  logic         EnDe,
  input  logic         Cbc,
  input  logic         IvLoad,
  input  logic [127:0] Iv,
  input  logic [31:0]  InData,
  input  logic         InValid,
  output logic         InReady,
  output logic [31:0]  OutData,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] DpBlock,
  output logic [127:0] DpKey,
  output logic         DpEnDe,
  output logic         DpStart,
  output logic         DpReset,
  input  logic [127:0] DpO,
  input  logic         DpBusy,
  output logic         InBusy,
  output logic         Err
);

  localparam int unsigned BW = 128;
  localparam int unsigned WW = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DPRST, S_START, S_WAITHI, S_RUN, S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [BW-1:0]   chain_q, chain_d;
  logic [BW-1:0]   res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ende_q, ende_d;
  logic            cbc_q, cbc_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [WW-1:0]   out_data_q, out_data_d;
  logic            dp_start_q, dp_start_d;
  logic            dp_reset_q, dp_reset_d;
  logic [BW-1:0]   dp_block_q, dp_block_d;
  logic            err_q, err_d;
  logic            in_busy_q, in_busy_d;
  logic            in_acc, out_acc;
  logic [CW-1:0]   cnt_inc;
  logic            cnt_hit;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    blk_d      = blk_q;
    chain_d    = chain_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    ende_d     = ende_q;
    cbc_d      = cbc_q;
    dp_block_d = dp_block_q;
    err_d      = err_q;

    in_acc  = InValid && in_ready_q;
    out_acc = out_valid_q && OutReady;
    cnt_inc = cnt_q + CW'(1);
    cnt_hit = (cnt_q == CW'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: begin
        // IV load lands before a coincident word 0 so it chains into that block
        if (IvLoad) chain_d = Iv;
        if (in_acc) begin
          ende_d  = EnDe;
          cbc_d   = Cbc;
          blk_d   = {blk_q[BW-WW-1:0], InData};
          wcnt_d  = 2'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_acc) begin
          blk_d = {blk_q[BW-WW-1:0], InData};
          if (wcnt_q == 2'd3) begin
            wcnt_d     = 2'd0;
            dp_block_d = (!ende_q && cbc_q) ? (blk_d ^ chain_q) : blk_d;
            state_d    = S_DPRST;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
      S_DPRST: begin
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = cnt_inc;
        state_d = S_WAITHI;
      end
      S_WAITHI: begin
        if (DpBusy) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (cnt_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        if (!DpBusy) begin
          if (cbc_q && ende_q) begin
            res_d   = DpO ^ chain_q;
            chain_d = blk_q;
          end else if (cbc_q) begin
            res_d   = DpO;
            chain_d = DpO;
          end else begin
            res_d = DpO;
          end
          wcnt_d  = 2'd0;
          state_d = S_DRAIN;
        end else if (cnt_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DRAIN: begin
        if (out_acc) begin
          if (wcnt_q == 2'd3) begin
            wcnt_d  = 2'd0;
            state_d = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    in_busy_d   = (state_d != S_IDLE);
    dp_reset_d  = (state_d == S_DPRST);
    dp_start_d  = (state_d == S_START);
    out_valid_d = (state_d == S_DRAIN);
    out_data_d  = (state_d == S_DRAIN) ? res_d[{2'd3 - wcnt_d, 5'd0} +: WW] : '0;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      blk_q       <= '0;
      chain_q     <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      ende_q      <= 1'b0;
      cbc_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      dp_start_q  <= 1'b0;
      dp_reset_q  <= 1'b0;
      dp_block_q  <= '0;
      err_q       <= 1'b0;
      in_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      blk_q       <= blk_d;
      chain_q     <= chain_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      ende_q      <= ende_d;
      cbc_q       <= cbc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      dp_start_q  <= dp_start_d;
      dp_reset_q  <= dp_reset_d;
      dp_block_q  <= dp_block_d;
      err_q       <= err_d;
      in_busy_q   <= in_busy_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutData  = out_data_q;
  assign OutValid = out_valid_q;
  assign DpBlock  = dp_block_q;
  assign DpKey    = Key;
  assign DpEnDe   = ende_q;
  assign DpStart  = dp_start_q;
  assign DpReset  = dp_reset_q;
  assign InBusy   = in_busy_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_tf_word_ctrl.sv
// Bench for tf_word_ctrl: stub core with an invertible stand-in cipher and a
// block-level CBC/ECB reference model.
module tb_tf_word_ctrl;

  localparam logic [127:0] CT0 = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [127:0] Key = '0;
  logic         EnDe = 1'b0;
  logic         Cbc = 1'b0;
  logic         IvLoad = 1'b0;
  logic [127:0] Iv = '0;
  logic [31:0]  InData = '0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [31:0]  OutData;
  logic         OutValid;
  logic         OutReady = 1'b0;
  logic [127:0] DpBlock;
  logic [127:0] DpKey;
  logic         DpEnDe;
  logic         DpStart;
  logic         DpReset;
  logic [127:0] DpO = '0;
  logic         DpBusy = 1'b0;
  logic         InBusy;
  logic         Err;

  tf_word_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Key(Key), .EnDe(EnDe), .Cbc(Cbc),
    .IvLoad(IvLoad), .Iv(Iv), .InData(InData), .InValid(InValid),
    .InReady(InReady), .OutData(OutData), .OutValid(OutValid),
    .OutReady(OutReady), .DpBlock(DpBlock), .DpKey(DpKey), .DpEnDe(DpEnDe),
    .DpStart(DpStart), .DpReset(DpReset), .DpO(DpO), .DpBusy(DpBusy),
    .InBusy(InBusy), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: enc(0, key 0) gives the Twofish zero vector, dec inverts enc
  function automatic logic [127:0] core_f(input logic [127:0] x, input logic [127:0] k,
                                          input logic de);
    logic [127:0] t;
    if (!de) begin
      t = x ^ k;
      return {t[114:0], t[127:115]} ^ CT0;
    end
    t = x ^ CT0;
    t = {t[12:0], t[127:13]};
    return t ^ k;
  endfunction

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Stub core plus start/output monitors
  bit           stub_dead = 1'b0;
  int           pre_dly = 0;
  int           busy_len = 3;
  int           phase = 0;
  int           scnt = 0;
  logic [127:0] s_blk = '0;
  logic [127:0] s_key = '0;
  logic         s_de = 1'b0;
  int           start_cnt = 0;
  int           start_cyc = 0;
  int           dbl_start = 0;
  logic         prev_start = 1'b0;
  int           ov_cnt = 0;

  always @(posedge Clk) begin
    prev_start <= DpStart;
    if (DpStart && prev_start) dbl_start <= dbl_start + 1;
    if (OutValid) ov_cnt <= ov_cnt + 1;
    if (DpStart) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
      s_blk     <= DpBlock;
      s_key     <= DpKey;
      s_de      <= DpEnDe;
    end
    if (Reset || DpReset) begin
      DpBusy <= 1'b0;
      phase  <= 0;
    end else if (DpStart && !stub_dead) begin
      phase <= 1;
      scnt  <= pre_dly;
    end else if (phase == 1) begin
      if (scnt == 0) begin
        DpBusy <= 1'b1;
        phase  <= 2;
        scnt   <= busy_len - 1;
      end else scnt <= scnt - 1;
    end else if (phase == 2) begin
      if (scnt == 0) begin
        DpBusy <= 1'b0;
        DpO    <= core_f(s_blk, s_key, s_de);
        phase  <= 0;
      end else scnt <= scnt - 1;
    end
  end

  logic [127:0] m_chain = '0;

  task automatic put_word(input logic [31:0] w, input bit ivl, output int acc_cyc);
    int n;
    n = 0;
    InData  = w;
    InValid = 1'b1;
    IvLoad  = ivl;
    while (InReady !== 1'b1 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) check_eq("in_ready_wait", 128'(n), 128'(0));
    acc_cyc = cyc;
    @(negedge Clk);
    InValid = 1'b0;
    IvLoad  = 1'b0;
    InData  = 32'($urandom);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset   = 1'b0;
    m_chain = '0;
  endtask

  // mode 0: random OutReady; mode 1: hold off 10 cycles then toggle
  task automatic recv_block(input logic [127:0] r, input int mode, input int exp_cyc);
    int k, n;
    bit first, tog;
    k = 0; n = 0; first = 1'b1; tog = 1'b1;
    while (k < 4 && n < 1000) begin
      if (OutValid === 1'b1) begin
        if (first) begin
          first = 1'b0;
          check_eq("latency", 128'(cyc), 128'(exp_cyc));
          if (mode == 1) begin
            for (int j = 0; j < 10; j++) begin
              OutReady = 1'b0;
              check_eq("bp_hold_data", 128'(OutData), 128'(r[127:96]));
              check_eq("bp_in_ready", 128'(InReady), 128'(0));
              @(negedge Clk);
            end
          end
        end
        if (mode == 0) OutReady = 1'($urandom_range(0, 1));
        else begin
          OutReady = tog;
          tog = ~tog;
        end
        if (OutReady) begin
          check_eq("out_word", 128'(OutData), 128'(r[127-32*k -: 32]));
          k++;
        end
      end else OutReady = 1'b0;
      @(negedge Clk);
      n++;
    end
    OutReady = 1'b0;
    if (k < 4) check_eq("out_timeout", 128'(k), 128'(4));
    check_eq("drain_done", 128'(OutValid), 128'(0));
  endtask

  // ivmode: 0 none, 1 IvLoad alone in IDLE, 2 with word 0, 3 with word 2 (ignored)
  task automatic run_block(input logic [127:0] p, input bit de, input bit cbc,
                           input int ivmode, input logic [127:0] iv, input int rxmode);
    logic [127:0] blk_in, r;
    int c, t3, s0;
    Iv = iv;
    if (ivmode == 1) begin
      IvLoad = 1'b1;
      @(negedge Clk);
      IvLoad  = 1'b0;
      m_chain = iv;
    end
    if (ivmode == 2) m_chain = iv;
    if (!de) begin
      blk_in = cbc ? (p ^ m_chain) : p;
      r      = core_f(blk_in, Key, 1'b0);
      if (cbc) m_chain = r;
    end else begin
      blk_in = p;
      r      = core_f(p, Key, 1'b1) ^ (cbc ? m_chain : 128'(0));
      if (cbc) m_chain = p;
    end
    s0 = start_cnt;
    t3 = 0;
    for (int i = 0; i < 4; i++) begin
      EnDe = de;
      Cbc  = cbc;
      put_word(p[127-32*i -: 32], (ivmode == 2 && i == 0) || (ivmode == 3 && i == 2), c);
      EnDe = 1'($urandom_range(0, 1));
      Cbc  = 1'($urandom_range(0, 1));
      if (i == 3) t3 = c;
      else repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    recv_block(r, rxmode, t3 + 5 + pre_dly + busy_len);
    check_eq("dp_block", s_blk, blk_in);
    check_eq("dp_ende", 128'(s_de), 128'(de));
    check_eq("dp_key", s_key, Key);
    check_eq("start_pulses", 128'(start_cnt - s0), 128'(1));
  endtask

  initial begin
    int c, s0, n, ov0;
    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    check_eq("rst_in_ready", 128'(InReady), 128'(1));
    check_eq("rst_out_valid", 128'(OutValid), 128'(0));
    check_eq("rst_out_data", 128'(OutData), 128'(0));
    check_eq("rst_dp_ctl", 128'({DpStart, DpReset, DpEnDe, InBusy}), 128'(0));
    check_eq("rst_dp_block", DpBlock, 128'(0));
    check_eq("rst_err", 128'(Err), 128'(0));
    Reset = 1'b0;
    @(negedge Clk);

    // ECB encrypt / decrypt of the zero vector
    pre_dly = 0; busy_len = 4;
    run_block(128'(0), 1'b0, 1'b0, 0, '0, 0);
    run_block(CT0, 1'b1, 1'b0, 0, '0, 0);
    check_eq("err_after_ecb", 128'(Err), 128'(0));

    // CBC encrypt of two zero blocks from a zero IV
    run_block(128'(0), 1'b0, 1'b1, 1, '0, 0);
    run_block(128'(0), 1'b0, 1'b1, 0, '0, 0);

    // Output backpressure
    do_reset();
    run_block(128'(0), 1'b0, 1'b0, 0, '0, 1);

    // Reset after word 2
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) put_word(32'(i + 7), 1'b0, c);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("midrst_in_ready", 128'(InReady), 128'(1));
    check_eq("midrst_in_busy", 128'(InBusy), 128'(0));
    Reset   = 1'b0;
    m_chain = '0;
    repeat (10) @(negedge Clk);
    check_eq("midrst_no_start", 128'(start_cnt), 128'(s0));
    run_block(128'(0), 1'b0, 1'b0, 0, '0, 0);

    // Randomized blocks
    for (int b = 0; b < 12; b++) begin
      Key      = {$urandom, $urandom, $urandom, $urandom};
      pre_dly  = $urandom_range(0, 3);
      busy_len = $urandom_range(1, 6);
      run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                {$urandom, $urandom, $urandom, $urandom}, 0);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end

    // Dead core: timeout waiting for busy
    stub_dead = 1'b1;
    ov0 = ov_cnt;
    for (int i = 0; i < 4; i++) put_word(32'($urandom), 1'b0, c);
    n = 0;
    while (Err !== 1'b1 && n < 600) begin
      @(negedge Clk);
      n++;
    end
    check_eq("err_delay", 128'(cyc - start_cyc), 128'(255));
    check_eq("err_no_out", 128'(ov_cnt - ov0), 128'(0));
    check_eq("err_idle_ready", 128'(InReady), 128'(1));
    put_word(32'h1234_5678, 1'b0, c);
    check_eq("err_accept_w0", 128'(InBusy), 128'(1));
    check_eq("err_sticky", 128'(Err), 128'(1));
    stub_dead = 1'b0;
    do_reset();
    check_eq("err_cleared", 128'(Err), 128'(0));
    check_eq("start_single_cycle", 128'(dbl_start), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
